// File: rtl/minute_hour_counter.sv
// Minutes/hours stage behind the seconds counter. In run mode it follows the seconds wrap.
// In set mode the two buttons step one field, with hold-to-auto-repeat.
//
// Button repeat FSM (one per button):
//   state     | meaning
//   ST_HOLD   | released, or held and waiting out HOLD_CYCLES before the first repeat
//   ST_REPEAT | held past the hold time; one event every REPEAT_CYCLES
module minute_hour_counter #(
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 12500000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sec_wrap_i,
   input  logic       mode_i,
   input  logic       sel_i,
   input  logic       add_n_i,
   input  logic       deduct_n_i,
   output logic [5:0] minute_o,
   output logic [4:0] hour_o,
   output logic       minute_wrap_o,
   output logic       day_wrap_o
);

   localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);

   typedef enum logic {ST_HOLD, ST_REPEAT} state_t;

   // Index 0 = add button, index 1 = deduct button
   logic [1:0]    btn_n;
   logic [1:0]    s1_q, s2_q, p_q;
   state_t        state_q [2];
   state_t        state_d [2];
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [1:0]    btn_ev;

   logic       inc_q, dec_q, sec_q;
   logic       ev_sec;
   logic [5:0] minute_q, minute_d;
   logic [4:0] hour_q, hour_d;
   logic       mwrap_q, mwrap_d, dwrap_q, dwrap_d;

   assign btn_n = {deduct_n_i, add_n_i};

   always_comb begin
      btn_ev = 2'b00;
      for (int b = 0; b < 2; b++) begin
         state_d[b] = state_q[b];
         cnt_d[b]   = cnt_q[b] + CW'(1);
         if (!mode_i || s2_q[b]) begin
            state_d[b] = ST_HOLD;
            cnt_d[b]   = '0;
         end else begin
            case (state_q[b])
               ST_HOLD: begin
                  if (cnt_q[b] == HOLD_TC) begin
                     btn_ev[b]  = 1'b1;
                     state_d[b] = ST_REPEAT;
                     cnt_d[b]   = '0;
                  end
               end
               ST_REPEAT: begin
                  if (cnt_q[b] == REPEAT_TC) begin
                     btn_ev[b] = 1'b1;
                     cnt_d[b]  = '0;
                  end
               end
               default: state_d[b] = ST_HOLD;
            endcase
         end
         if (mode_i && p_q[b] && !s2_q[b]) btn_ev[b] = 1'b1;
      end
   end

   always_comb begin
      minute_d = minute_q;
      hour_d   = hour_q;
      mwrap_d  = 1'b0;
      dwrap_d  = 1'b0;
      ev_sec   = sec_wrap_i & ~sec_q;
      if (!mode_i) begin
         if (ev_sec) begin
            if (minute_q == 6'd59) begin
               minute_d = 6'd0;
               mwrap_d  = 1'b1;
               if (hour_q == 5'd23) begin
                  hour_d  = 5'd0;
                  dwrap_d = 1'b1;
               end else begin
                  hour_d = hour_q + 5'd1;
               end
            end else begin
               minute_d = minute_q + 6'd1;
            end
         end
      end else if (inc_q ^ dec_q) begin
         // Set mode edits one field only; no carry/borrow between fields
         if (sel_i) begin
            if (inc_q) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            else       hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
         end else begin
            if (inc_q) minute_d = (minute_q == 6'd59) ? 6'd0 : minute_q + 6'd1;
            else       minute_d = (minute_q == 6'd0) ? 6'd59 : minute_q - 6'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q     <= 2'b11;
         s2_q     <= 2'b11;
         p_q      <= 2'b11;
         for (int b = 0; b < 2; b++) begin
            state_q[b] <= ST_HOLD;
            cnt_q[b]   <= '0;
         end
         inc_q    <= 1'b0;
         dec_q    <= 1'b0;
         sec_q    <= 1'b0;
         minute_q <= 6'd0;
         hour_q   <= 5'd0;
         mwrap_q  <= 1'b0;
         dwrap_q  <= 1'b0;
      end else begin
         s1_q     <= btn_n;
         s2_q     <= s1_q;
         p_q      <= s2_q;
         for (int b = 0; b < 2; b++) begin
            state_q[b] <= state_d[b];
            cnt_q[b]   <= cnt_d[b];
         end
         inc_q    <= btn_ev[0];
         dec_q    <= btn_ev[1];
         sec_q    <= sec_wrap_i;
         minute_q <= minute_d;
         hour_q   <= hour_d;
         mwrap_q  <= mwrap_d;
         dwrap_q  <= dwrap_d;
      end
   end

   assign minute_o      = minute_q;
   assign hour_o        = hour_q;
   assign minute_wrap_o = mwrap_q;
   assign day_wrap_o    = dwrap_q;

endmodule

// File: tb/tb_minute_hour_counter.sv
// Bench for minute_hour_counter: directed corner sequences, a set-mode vector table,
// then randomized run/set segments checked against a time-of-day reference model.
module tb_minute_hour_counter;

   localparam int HOLD   = 8;
   localparam int REPEAT = 4;

   logic       clk = 1'b0;
   logic       rst, sec, mode, sel, add_n, ded_n;
   logic [5:0] minute;
   logic [4:0] hour;
   logic       mwrap, dwrap;

   int checks = 0;
   int errors = 0;
   int mw_seen = 0;
   int dw_seen = 0;

   // Reference model: time as plain integers, buttons as run lengths of low samples
   int m_min, m_hr, m_mw, m_dw, m_sec_prev;
   int arun, drun, ec, last_rst;
   int aring [8];
   int dring [8];

   typedef struct {
      logic sel;
      logic use_add;
      int   exp_min;
      int   exp_hr;
   } vec_t;
   vec_t tbl [9];

   minute_hour_counter #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT)) dut (
      .clk_i(clk), .rst_i(rst), .sec_wrap_i(sec), .mode_i(mode), .sel_i(sel),
      .add_n_i(add_n), .deduct_n_i(ded_n),
      .minute_o(minute), .hour_o(hour), .minute_wrap_o(mwrap), .day_wrap_o(dwrap)
   );

   always #5 clk = ~clk;

   // A held button yields an event for the press, one after HOLD cycles, then every REPEAT
   function automatic bit fires(int r);
      int k;
      if (r <= 0) return 1'b0;
      k = r - 1;
      return (k == 0) || (k == HOLD - 1) || (k > HOLD - 1 && ((k - (HOLD - 1)) % REPEAT) == 0);
   endfunction

   task automatic model_edge();
      bit a, d;
      ec++;
      if (rst) begin
         m_min = 0; m_hr = 0; m_mw = 0; m_dw = 0; m_sec_prev = 0;
         arun = 0; drun = 0;
         aring[ec % 8] = 0; dring[ec % 8] = 0;
         last_rst = ec;
         return;
      end
      m_mw = 0; m_dw = 0;
      arun = add_n ? 0 : arun + 1;
      drun = ded_n ? 0 : drun + 1;
      aring[ec % 8] = arun;
      dring[ec % 8] = drun;
      if (!mode) begin
         if (sec && !m_sec_prev) begin
            m_min = m_min + 1;
            if (m_min == 60) begin
               m_min = 0; m_mw = 1;
               m_hr = m_hr + 1;
               if (m_hr == 24) begin m_hr = 0; m_dw = 1; end
            end
         end
      end else if (ec - 3 > last_rst) begin
         a = fires(aring[(ec - 3) % 8]);
         d = fires(dring[(ec - 3) % 8]);
         if (a != d) begin
            if (sel) m_hr  = a ? (m_hr + 1) % 24  : (m_hr + 23) % 24;
            else     m_min = a ? (m_min + 1) % 60 : (m_min + 59) % 60;
         end
      end
      m_sec_prev = sec;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (mwrap) mw_seen++;
      if (dwrap) dw_seen++;
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("rnd_minute", int'(minute), m_min);
      check("rnd_hour", int'(hour), m_hr);
      check("rnd_mwrap", int'(mwrap), m_mw);
      check("rnd_dwrap", int'(dwrap), m_dw);
   endtask

   initial begin
      int mw0, dw0, bad;
      tbl[0] = '{1'b0, 1'b0, 1, 1};
      tbl[1] = '{1'b0, 1'b0, 0, 1};
      tbl[2] = '{1'b0, 1'b0, 59, 1};
      tbl[3] = '{1'b0, 1'b1, 0, 1};
      tbl[4] = '{1'b1, 1'b0, 0, 0};
      tbl[5] = '{1'b1, 1'b0, 0, 23};
      tbl[6] = '{1'b1, 1'b1, 0, 0};
      tbl[7] = '{1'b1, 1'b0, 0, 23};
      tbl[8] = '{1'b0, 1'b0, 59, 23};
      ec = 0; last_rst = 0; arun = 0; drun = 0;
      m_min = 0; m_hr = 0; m_mw = 0; m_dw = 0; m_sec_prev = 0;
      for (int i = 0; i < 8; i++) begin aring[i] = 0; dring[i] = 0; end

      rst = 1'b1; sec = 1'b0; mode = 1'b0; sel = 1'b0; add_n = 1'b1; ded_n = 1'b1;
      steps(2);
      rst = 1'b0;
      step();
      check("rst_minute", int'(minute), 0);
      check("rst_hour", int'(hour), 0);
      check("rst_mwrap", int'(mwrap), 0);
      check("rst_dwrap", int'(dwrap), 0);

      // 60 one-cycle seconds wraps
      mw0 = mw_seen; dw0 = dw_seen;
      for (int i = 1; i <= 60; i++) begin
         sec = 1'b1; step();
         check("run_minute", int'(minute), i % 60);
         sec = 1'b0; step();
      end
      check("run_hour", int'(hour), 1);
      check("run_mwrap_count", mw_seen - mw0, 1);
      check("run_dwrap_count", dw_seen - dw0, 0);

      // Long sec_wrap level counts once
      sec = 1'b1; steps(10);
      sec = 1'b0; steps(2);
      check("level_minute", int'(minute), 1);
      check("level_hour", int'(hour), 1);

      // Single press latency: count changes three edges after the first low sample
      mode = 1'b1; sel = 1'b0; steps(2);
      add_n = 1'b0;
      step(); check("press_n0", int'(minute), 1);
      step(); check("press_n1", int'(minute), 1);
      step(); check("press_n2", int'(minute), 1);
      add_n = 1'b1;
      step(); check("press_n3", int'(minute), 2);
      steps(6); check("press_settle", int'(minute), 2);

      // Set-mode vector table: one short press per entry
      mw0 = mw_seen; dw0 = dw_seen;
      for (int i = 0; i < 9; i++) begin
         sel = tbl[i].sel; step();
         if (tbl[i].use_add) add_n = 1'b0; else ded_n = 1'b0;
         steps(3);
         add_n = 1'b1; ded_n = 1'b1;
         steps(6);
         check("tbl_minute", int'(minute), tbl[i].exp_min);
         check("tbl_hour", int'(hour), tbl[i].exp_hr);
      end
      check("set_no_wrap", (mw_seen - mw0) + (dw_seen - dw0), 0);

      // 23:59 -> 00:00 in run mode
      mode = 1'b0; steps(2);
      sec = 1'b1; step();
      check("day_minute", int'(minute), 0);
      check("day_hour", int'(hour), 0);
      check("day_mwrap_hi", int'(mwrap), 1);
      check("day_dwrap_hi", int'(dwrap), 1);
      sec = 1'b0; step();
      check("day_mwrap_lo", int'(mwrap), 0);
      check("day_dwrap_lo", int'(dwrap), 0);

      // Hold-to-repeat on hours: press + hold + 3 repeats
      mode = 1'b1; sel = 1'b1; steps(2);
      add_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 9)  check("hold_before_rep", int'(hour), 1);
         if (i == 10) check("hold_first_rep", int'(hour), 2);
      end
      add_n = 1'b1;
      steps(10);
      check("hold_hour", int'(hour), 5);
      check("hold_minute", int'(minute), 0);
      steps(10);
      check("hold_released", int'(hour), 5);

      // Both buttons together, then reset mid-hold
      sel = 1'b0; step();
      add_n = 1'b0; ded_n = 1'b0;
      steps(14);
      check("both_minute", int'(minute), 0);
      check("both_hour", int'(hour), 5);
      rst = 1'b1; steps(2);
      check("midrst_minute", int'(minute), 0);
      check("midrst_hour", int'(hour), 0);
      check("midrst_wraps", int'(mwrap) + int'(dwrap), 0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (minute != 6'd0 || hour != 5'd0) bad++;
      end
      check("postrst_no_event", bad, 0);
      add_n = 1'b1; ded_n = 1'b1; steps(5);

      // Randomized run/set segments against the model
      rst = 1'b1; mode = 1'b0; steps(2);
      rst = 1'b0; step();
      check_model();
      for (int s = 0; s < 30; s++) begin
         if ($urandom_range(0, 1) == 0) begin
            mode = 1'b1;
            for (int i = 0, n = $urandom_range(10, 60); i < n; i++) begin
               if ($urandom_range(0, 7) == 0) add_n = ~add_n;
               if ($urandom_range(0, 7) == 0) ded_n = ~ded_n;
               if ($urandom_range(0, 15) == 0) sel = ~sel;
               sec = ($urandom_range(0, 3) == 0);
               step(); check_model();
            end
            add_n = 1'b1; ded_n = 1'b1;
            for (int i = 0; i < 4; i++) begin step(); check_model(); end
         end else begin
            mode = 1'b0;
            for (int i = 0, n = $urandom_range(20, 200); i < n; i++) begin
               sec = ($urandom_range(0, 2) == 0);
               sel = $urandom_range(0, 1);
               step(); check_model();
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
